// File: rtl/riscv_fetch_pkg.sv
// Shared types and helpers for the RV32IC fetch alignment stage.
package riscv_fetch_pkg;

  localparam int HW_BUF_DEPTH = 4;

  typedef logic [15:0] halfword_t;

  typedef enum logic {
    RUN     = 1'b0,
    SKIP_LO = 1'b1
  } fetch_align_state_e;

  // A halfword starts a 16-bit instruction unless its two LSBs are both set.
  function automatic logic is_compressed(input halfword_t hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/riscv_hw_buffer.sv
// Four-entry halfword circular FIFO; can take 1 or 2 halfwords and release 1 or 2 per cycle.
module riscv_hw_buffer
  import riscv_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      clear,
  input  logic      push1,
  input  logic      push2,
  input  halfword_t wr_hw0,
  input  halfword_t wr_hw1,
  input  logic      pop1,
  input  logic      pop2,
  output halfword_t head0,
  output halfword_t head1,
  output logic [2:0] count
);

  halfword_t  mem [HW_BUF_DEPTH];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [1:0] wr_nxt;
  logic [1:0] rd_nxt;
  logic [2:0] push_n;
  logic [2:0] pop_n;

  assign wr_nxt = wr_ptr + 2'd1;
  assign rd_nxt = rd_ptr + 2'd1;
  assign push_n = {1'b0, push2, push1};
  assign pop_n  = {1'b0, pop2, pop1};

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_nxt];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else if (clear) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      wr_ptr <= wr_ptr + push_n[1:0];
      rd_ptr <= rd_ptr + pop_n[1:0];
      count  <= count + push_n - pop_n;
    end
  end

  // Storage is not reset: entries are only observed once count covers them.
  always_ff @(posedge clk) begin
    if (!clear && (push1 || push2)) begin
      mem[wr_ptr] <= wr_hw0;
    end
    if (!clear && push2) begin
      mem[wr_nxt] <= wr_hw1;
    end
  end

endmodule

// File: rtl/riscv_fetch_align.sv
// RV32IC fetch alignment: splits fetch words into halfwords and presents whole instructions.
// Optional macro RISCV_FETCH_ALIGN_PERF_EN adds compressed / full-length pop counters.
module riscv_fetch_align
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [31:0]     fetch_data_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            instr_compressed_o
`ifdef RISCV_FETCH_ALIGN_PERF_EN
  ,
  output logic [31:0]     perf_rvc_cnt_o,
  output logic [31:0]     perf_rvi_cnt_o
`endif
);

  fetch_align_state_e state_q;
  fetch_align_state_e state_d;
  logic [XLEN-1:0]    pc_q;
  logic [2:0]         count;
  halfword_t          head0;
  halfword_t          head1;
  logic               head_c;
  logic [2:0]         need;
  logic               push;
  logic               pop;
  logic               skip;
  logic [2:0]         pc_inc;

  assign fetch_ready_o = (count <= 3'd2);
  assign push          = fetch_valid_i && fetch_ready_o;
  assign skip          = (state_q == SKIP_LO);

  assign head_c        = is_compressed(head0);
  assign need          = head_c ? 3'd1 : 3'd2;
  assign instr_valid_o = (count >= need);
  assign pop           = instr_valid_o && instr_ready_i && !flush_i;
  assign pc_inc        = head_c ? 3'd2 : 3'd4;

  riscv_hw_buffer u_buf (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush_i),
    .push1  (push && skip),
    .push2  (push && !skip),
    .wr_hw0 (skip ? fetch_data_i[31:16] : fetch_data_i[15:0]),
    .wr_hw1 (fetch_data_i[31:16]),
    .pop1   (pop && head_c),
    .pop2   (pop && !head_c),
    .head0  (head0),
    .head1  (head1),
    .count  (count)
  );

  // Outputs read 0 while nothing is presented, so stale storage never leaks out.
  assign instr_o            = !instr_valid_o ? 32'h0 :
                              head_c ? {16'h0, head0} : {head1, head0};
  assign instr_compressed_o = instr_valid_o && head_c;
  assign instr_pc_o         = pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = flush_pc_i[1] ? SKIP_LO : RUN;
    end else if (push && skip) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (flush_i) begin
      pc_q <= flush_pc_i;
    end else if (pop) begin
      pc_q <= pc_q + {{(XLEN-3){1'b0}}, pc_inc};
    end
  end

`ifdef RISCV_FETCH_ALIGN_PERF_EN
  // Redirects do not clear these; only reset does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_rvc_cnt_o <= 32'd0;
      perf_rvi_cnt_o <= 32'd0;
    end else if (pop) begin
      if (head_c) begin
        perf_rvc_cnt_o <= perf_rvc_cnt_o + 32'd1;
      end else begin
        perf_rvi_cnt_o <= perf_rvi_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_riscv_fetch_align.sv
// Self-checking bench for riscv_fetch_align: directed vector table, reset sequence, random vs queue model.
module tb_riscv_fetch_align;

  logic        clk;
  logic        reset;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;
`ifdef RISCV_FETCH_ALIGN_PERF_EN
  logic [31:0] perf_rvc_cnt_o;
  logic [31:0] perf_rvi_cnt_o;
`endif

  riscv_fetch_align #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
    .clk                (clk),
    .reset              (reset),
    .flush_i            (flush_i),
    .flush_pc_i         (flush_pc_i),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_ready_o      (fetch_ready_o),
    .fetch_data_i       (fetch_data_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .instr_o            (instr_o),
    .instr_pc_o         (instr_pc_o),
    .instr_compressed_o (instr_compressed_o)
`ifdef RISCV_FETCH_ALIGN_PERF_EN
    ,
    .perf_rvc_cnt_o     (perf_rvc_cnt_o),
    .perf_rvi_cnt_o     (perf_rvi_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: halfword queue, PC and a drop-next-low flag.
  logic [15:0] mq[$];
  logic [31:0] m_pc;
  bit          m_skip;
  int          m_rvc;
  int          m_rvi;

  task automatic model_reset();
    mq.delete();
    m_pc   = 32'h8000_0000;
    m_skip = 0;
    m_rvc  = 0;
    m_rvi  = 0;
  endtask

  function automatic int m_need();
    if (mq.size() == 0) return 1;
    return (mq[0][1:0] != 2'b11) ? 1 : 2;
  endfunction

  function automatic bit m_valid();
    return mq.size() > 0 && mq.size() >= m_need();
  endfunction

  function automatic bit m_ready();
    return mq.size() <= 2;
  endfunction

  function automatic logic [31:0] m_instr();
    if (m_need() == 1) return {16'h0, mq[0]};
    return {mq[1], mq[0]};
  endfunction

  task automatic model_step();
    bit v, r;
    int n;
    v = m_valid();
    r = m_ready();
    n = m_need();
    if (flush_i) begin
      mq.delete();
      m_pc   = flush_pc_i;
      m_skip = flush_pc_i[1];
    end else begin
      if (v && instr_ready_i) begin
        if (n == 1) m_rvc++; else m_rvi++;
        for (int k = 0; k < n; k++) void'(mq.pop_front());
        m_pc = m_pc + 32'(2 * n);
      end
      if (fetch_valid_i && r) begin
        if (m_skip) begin
          mq.push_back(fetch_data_i[31:16]);
          m_skip = 0;
        end else begin
          mq.push_back(fetch_data_i[15:0]);
          mq.push_back(fetch_data_i[31:16]);
        end
      end
    end
  endtask

  task automatic drive(input logic fl, input logic [31:0] fpc, input logic fv,
                       input logic [31:0] fd, input logic rdy);
    flush_i       = fl;
    flush_pc_i    = fpc;
    fetch_valid_i = fv;
    fetch_data_i  = fd;
    instr_ready_i = rdy;
    #1;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fl;
    logic [31:0] fpc;
    logic        fv;
    logic [31:0] fd;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] epc;
    logic        ec;
    logic        er;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic fl, input logic [31:0] fpc, input logic fv, input logic [31:0] fd,
                     input logic rdy, input logic ev, input logic [31:0] ei, input logic [31:0] epc,
                     input logic ec, input logic er);
    vec_t v;
    v.fl = fl; v.fpc = fpc; v.fv = fv; v.fd = fd; v.rdy = rdy;
    v.ev = ev; v.ei = ei; v.epc = epc; v.ec = ec; v.er = er;
    vt.push_back(v);
  endtask

  initial begin
    // Expected outputs are those seen during the row's cycle, before its clock edge.
    add(0, 0, 1, 32'h0041_8193, 1, 0, 0,            32'h8000_0000, 0, 1);
    add(0, 0, 0, 0,             1, 1, 32'h0041_8193, 32'h8000_0000, 0, 1);
    add(0, 0, 1, 32'h4505_0505, 1, 0, 0,            32'h8000_0004, 0, 1);
    add(0, 0, 0, 0,             1, 1, 32'h0000_0505, 32'h8000_0004, 1, 1);
    add(0, 0, 0, 0,             1, 1, 32'h0000_4505, 32'h8000_0006, 1, 1);
    add(0, 0, 1, 32'h8193_0505, 1, 0, 0,            32'h8000_0008, 0, 1);
    add(0, 0, 0, 0,             1, 1, 32'h0000_0505, 32'h8000_0008, 1, 1);
    add(0, 0, 0, 0,             1, 0, 0,            32'h8000_000A, 0, 1);
    add(0, 0, 1, 32'h1234_0041, 1, 0, 0,            32'h8000_000A, 0, 1);
    add(0, 0, 0, 0,             1, 1, 32'h0041_8193, 32'h8000_000A, 0, 0);
    add(1, 32'h8000_0102, 1, 32'h1111_1111, 1, 1, 32'h0000_1234, 32'h8000_000E, 1, 1);
    add(0, 0, 0, 0,             1, 0, 0,            32'h8000_0102, 0, 1);
    add(0, 0, 1, 32'h0001_DEAD, 1, 0, 0,            32'h8000_0102, 0, 1);
    add(0, 0, 0, 0,             0, 1, 32'h0000_0001, 32'h8000_0102, 1, 1);
    add(0, 0, 0, 0,             1, 1, 32'h0000_0001, 32'h8000_0102, 1, 1);
    add(0, 0, 1, 32'h0041_8193, 0, 0, 0,            32'h8000_0104, 0, 1);
    add(0, 0, 1, 32'h4505_0505, 0, 1, 32'h0041_8193, 32'h8000_0104, 0, 1);
    add(0, 0, 1, 32'h9999_9999, 0, 1, 32'h0041_8193, 32'h8000_0104, 0, 0);
    add(0, 0, 0, 0,             0, 1, 32'h0041_8193, 32'h8000_0104, 0, 0);
    add(0, 0, 0, 0,             1, 1, 32'h0041_8193, 32'h8000_0104, 0, 0);
    add(0, 0, 0, 0,             1, 1, 32'h0000_0505, 32'h8000_0108, 1, 1);
    add(0, 0, 0, 0,             1, 1, 32'h0000_4505, 32'h8000_010A, 1, 1);
    add(1, 32'h8000_0200, 0, 0, 1, 0, 0,            32'h8000_010C, 0, 1);
    add(0, 0, 1, 32'h0001_0001, 1, 0, 0,            32'h8000_0200, 0, 1);
    add(0, 0, 0, 0,             1, 1, 32'h0000_0001, 32'h8000_0200, 1, 1);
    add(0, 0, 0, 0,             1, 1, 32'h0000_0001, 32'h8000_0202, 1, 1);
    add(0, 0, 0, 0,             1, 0, 0,            32'h8000_0204, 0, 1);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 32'(fetch_ready_o), 32'd1);
    chk("reset valid", 32'(instr_valid_o), 32'd0);
    chk("reset instr", instr_o, 32'h0);
    chk("reset pc", instr_pc_o, 32'h8000_0000);
    chk("reset compressed", 32'(instr_compressed_o), 32'd0);
    reset = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i].fl, vt[i].fpc, vt[i].fv, vt[i].fd, vt[i].rdy);
      chk($sformatf("vec%0d ready", i), 32'(fetch_ready_o), 32'(vt[i].er));
      chk($sformatf("vec%0d valid", i), 32'(instr_valid_o), 32'(vt[i].ev));
      chk($sformatf("vec%0d pc", i), instr_pc_o, vt[i].epc);
      if (vt[i].ev) begin
        chk($sformatf("vec%0d instr", i), instr_o, vt[i].ei);
        chk($sformatf("vec%0d compressed", i), 32'(instr_compressed_o), 32'(vt[i].ec));
      end
      advance();
    end

`ifdef RISCV_FETCH_ALIGN_PERF_EN
    chk("perf rvc after table", perf_rvc_cnt_o, 32'd8);
    chk("perf rvi after table", perf_rvi_cnt_o, 32'd3);
`endif

    // Reset asserted mid-instruction: buffer holds a half of a 32-bit instruction.
    drive(0, 0, 1, 32'h8193_0505, 1);
    advance();
    drive(0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset valid", 32'(instr_valid_o), 32'd0);
    chk("midreset ready", 32'(fetch_ready_o), 32'd1);
    chk("midreset pc", instr_pc_o, 32'h8000_0000);
    chk("midreset instr", instr_o, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 0, 1, 32'h0000_0003, 1);
    advance();
    drive(0, 0, 0, 0, 1);
    chk("postreset valid", 32'(instr_valid_o), 32'd1);
    chk("postreset instr", instr_o, 32'h0000_0003);
    advance();
    drive(0, 0, 0, 0, 1);
    chk("postreset drained", 32'(instr_valid_o), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 1) == 0) d[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 0) d[17:16] = 2'b11;
      drive(($urandom_range(0, 99) < 3), {$urandom, 1'b0} & 32'hFFFF_FFFE,
            ($urandom_range(0, 99) < 70), d, ($urandom_range(0, 99) < 60));
      chk("rand ready", 32'(fetch_ready_o), 32'(m_ready()));
      chk("rand valid", 32'(instr_valid_o), 32'(m_valid()));
      chk("rand pc", instr_pc_o, m_pc);
      if (m_valid()) begin
        chk("rand instr", instr_o, m_instr());
        chk("rand compressed", 32'(instr_compressed_o), 32'(m_need() == 1));
      end
      advance();
    end

`ifdef RISCV_FETCH_ALIGN_PERF_EN
    chk("perf rvc final", perf_rvc_cnt_o, 32'(m_rvc));
    chk("perf rvi final", perf_rvi_cnt_o, 32'(m_rvi));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
